// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: accepts a cipher key, launches the expansion engine,
// captures its 11 round keys into a table and serves registered forward/reverse reads.
module aes_key_sched_ctrl #(
    parameter int unsigned NKEYS   = 11,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         kx_start,
    output logic [127:0] kx_key_out,
    input  logic [127:0] kx_rk_in,
    input  logic [1:0]   kx_state_in,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    input  logic         rk_dec,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_valid,
    output logic         rk_rd_err,
    output logic         keys_valid,
    output logic         busy,
    output logic         kx_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StCapture,
        StReady
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [127:0]      key_q, key_d;
    logic              kv_q, kv_d;
    logic              err_q, err_d;
    logic [127:0]      table_q [NKEYS];
    logic              wr_en;
    logic [3:0]        wr_idx;

    logic [127:0]      rd_data_q;
    logic              rd_valid_q, rd_err_q;
    logic [3:0]        rd_slot;
    logic              rd_ok;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tmo_q   <= '0;
            key_q   <= '0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        key_d   = key_q;
        kv_d    = kv_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        unique case (state_q)
            StIdle, StReady: begin
                if (key_valid) begin
                    key_d   = key_in;
                    kv_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (kx_state_in != 2'd0) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    cnt_d   = 4'd1;
                    state_d = StCapture;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TmoW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StCapture: begin
                if (kx_state_in != 2'd0) begin
                    wr_en  = 1'b1;
                    wr_idx = cnt_q;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(NKEYS - 1)) begin
                        kv_d    = 1'b1;
                        state_d = StReady;
                    end
                end else begin
                    // Engine went idle before the schedule was complete.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NKEYS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= kx_rk_in;
        end
    end

    // Reads see kv_q before any same-edge key acceptance clears it.
    assign rd_ok   = kv_q && (rk_rd_idx <= 4'(NKEYS - 1));
    assign rd_slot = rk_dec ? (4'(NKEYS - 1) - rk_rd_idx) : rk_rd_idx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rk_rd_en & rd_ok;
            rd_err_q   <= rk_rd_en & ~rd_ok;
            if (rk_rd_en) begin
                rd_data_q <= rd_ok ? table_q[rd_slot] : '0;
            end
        end
    end

    assign key_ready   = (state_q == StIdle) || (state_q == StReady);
    assign busy        = (state_q == StLaunch) || (state_q == StWait) || (state_q == StCapture);
    assign kx_start    = (state_q == StLaunch);
    assign kx_key_out  = key_q;
    assign keys_valid  = kv_q;
    assign kx_err      = err_q;
    assign rk_rd_data  = rd_data_q;
    assign rk_rd_valid = rd_valid_q;
    assign rk_rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: engine stub driven by an AES-128 key-expansion model,
// read responses checked by a scoreboard queue and an independent monitor.
module tb_aes_key_sched_ctrl;

    logic         CLK;
    logic         RST;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         kx_start;
    logic [127:0] kx_key_out;
    logic [127:0] kx_rk_in;
    logic [1:0]   kx_state_in;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic         rk_dec;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;
    logic         rk_rd_err;
    logic         keys_valid;
    logic         busy;
    logic         kx_err;

    aes_key_sched_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .key_valid   (key_valid),
        .key_in      (key_in),
        .key_ready   (key_ready),
        .kx_start    (kx_start),
        .kx_key_out  (kx_key_out),
        .kx_rk_in    (kx_rk_in),
        .kx_state_in (kx_state_in),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_dec      (rk_dec),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid),
        .rk_rd_err   (rk_rd_err),
        .keys_valid  (keys_valid),
        .busy        (busy),
        .kx_err      (kx_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         err;
        logic [127:0] data;
    } rd_exp_t;

    rd_exp_t      exp_q [$];
    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [11];
    logic [127:0] stub_rk [11];
    int           stub_n;
    bit           m_kv;
    logic [127:0] m_tab [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Engine stub: after seeing kx_start, streams stub_n round keys, then goes idle.
    initial begin
        kx_state_in = 2'd0;
        kx_rk_in    = '0;
        forever begin
            @(negedge CLK);
            if (kx_start === 1'b1) begin
                for (int i = 0; i < stub_n; i++) begin
                    @(posedge CLK);
                    #1;
                    kx_state_in = 2'($urandom_range(1, 3));
                    kx_rk_in    = stub_rk[i];
                end
                @(posedge CLK);
                #1;
                kx_state_in = 2'd0;
                kx_rk_in    = '0;
            end
        end
    end

    // Read monitor: pops the scoreboard on every response, otherwise checks data hold.
    initial begin
        rd_exp_t      e;
        logic [127:0] last_data = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                last_data = '0;
            end else if (rk_rd_valid || rk_rd_err) begin
                if (exp_q.size() == 0) begin
                    chk("rd_spurious", {126'd0, rk_rd_valid, rk_rd_err}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_valid", rk_rd_valid, !e.err);
                    chk("rd_err", rk_rd_err, e.err);
                    chk("rd_data", rk_rd_data, e.data);
                    last_data = e.data;
                end
            end else begin
                chk("rd_hold", rk_rd_data, last_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic rd_drive(input int idx, input bit dec);
        rd_exp_t e;
        int      slot;
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'(idx);
        rk_dec    = dec;
        slot      = dec ? 10 - idx : idx;
        if (!m_kv || idx > 10) begin
            e.err  = 1'b1;
            e.data = '0;
        end else begin
            e.err  = 1'b0;
            e.data = m_tab[slot];
        end
        exp_q.push_back(e);
    endtask

    task automatic do_read(input int idx, input bit dec);
        rd_drive(idx, dec);
        step();
        rk_rd_en = 1'b0;
    endtask

    task automatic status(input string tag, input logic kr, input logic by, input logic kv,
                          input logic ke);
        chk({tag, "_key_ready"}, key_ready, kr);
        chk({tag, "_busy"}, busy, by);
        chk({tag, "_keys_valid"}, keys_valid, kv);
        chk({tag, "_kx_err"}, kx_err, ke);
    endtask

    // Offers key, lets the stub supply n round keys, and checks the outcome timing.
    task automatic load_key(input logic [127:0] key, input int n, input bit poke,
                            input bit rd_at_accept);
        int last;
        expand(key);
        for (int i = 0; i < 11; i++) stub_rk[i] = exp_rk[i];
        stub_n    = n;
        key_valid = 1'b1;
        key_in    = key;
        if (rd_at_accept) rd_drive($urandom_range(0, 10), 1'($urandom));
        step();
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        m_kv      = 1'b0;
        sample();
        status("launch", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("launch_kx_start", kx_start, 1'b1);
        chk("launch_key_out", kx_key_out, key);
        last = (n >= 11) ? 12 : ((n == 0) ? 5 : n + 2);
        for (int c = 1; c <= last; c++) begin
            step();
            if (poke && last > 5 && c == 4) begin
                key_valid = 1'b1;
                key_in    = ~key;
                rd_drive($urandom_range(0, 10), 1'($urandom));
            end
            if (poke && last > 5 && c == 5) begin
                key_valid = 1'b0;
                rk_rd_en  = 1'b0;
            end
            sample();
            if (c == 1) chk("wait_kx_start", kx_start, 1'b0);
            if (c == last - 1) status("pre_end", 1'b0, 1'b1, 1'b0, 1'b0);
            if (c == last) begin
                if (n >= 11) status("done", 1'b1, 1'b0, 1'b1, 1'b0);
                else status("fault", 1'b1, 1'b0, 1'b0, 1'b1);
                chk("end_key_out", kx_key_out, key);
            end
        end
        if (n >= 11) begin
            m_kv = 1'b1;
            for (int i = 0; i < 11; i++) m_tab[i] = exp_rk[i];
        end
    endtask

    initial begin
        RST       = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = '0;
        rk_dec    = 1'b0;
        stub_n    = 11;
        m_kv      = 1'b0;
        for (int i = 0; i < 11; i++) m_tab[i] = '0;
        build_sbox();
        repeat (2) sample();
        status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_kx_start", kx_start, 1'b0);
        chk("reset_key_out", kx_key_out, '0);
        chk("reset_rd", {rk_rd_valid, rk_rd_err, rk_rd_data}, '0);
        #2;
        RST = 1'b1;
        step();

        // Known-answer schedule.
        load_key(128'h000102030405060708090a0b0c0d0e0f, 11, 1'b0, 1'b0);
        do_read(10, 1'b0);
        sample();
        chk("kat_rk10", rk_rd_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        step();
        do_read(0, 1'b1);
        sample();
        chk("kat_dec0", rk_rd_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        step();
        do_read(0, 1'b0);
        sample();
        chk("kat_fwd0", rk_rd_data, 128'h000102030405060708090a0b0c0d0e0f);
        step();
        do_read(11, 1'b0);
        do_read(15, 1'b1);
        do_read(5, 1'b1);
        step();

        // Engine never starts, then engine quits early; next acceptance clears the fault.
        load_key({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0);
        do_read(3, 1'b0);
        load_key({$urandom, $urandom, $urandom, $urandom}, 5, 1'b0, 1'b1);
        do_read(7, 1'b1);
        load_key({$urandom, $urandom, $urandom, $urandom}, 11, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) do_read($urandom_range(0, 12), 1'($urandom));

        // Reset in the middle of capturing.
        expand({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 11; i++) stub_rk[i] = exp_rk[i];
        stub_n    = 11;
        key_valid = 1'b1;
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        step();
        key_valid = 1'b0;
        repeat (7) step();
        RST = 1'b0;
        #1;
        status("abort", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_kx_start", kx_start, 1'b0);
        chk("abort_key_out", kx_key_out, '0);
        chk("abort_rd", {rk_rd_valid, rk_rd_err, rk_rd_data}, '0);
        m_kv = 1'b0;
        for (int i = 0; i < 11; i++) m_tab[i] = '0;
        repeat (8) step();
        RST = 1'b1;
        step();
        do_read(0, 1'b0);
        do_read(10, 1'b1);

        // Random schedules with a read on the accepting edge and random reads afterwards.
        for (int k = 0; k < 4; k++) begin
            load_key({$urandom, $urandom, $urandom, $urandom}, 11, 1'($urandom), 1'b1);
            for (int i = 0; i < 8; i++) begin
                do_read($urandom_range(0, 12), 1'($urandom));
                if ($urandom_range(0, 2) == 0) step();
            end
        end
        load_key({$urandom, $urandom, $urandom, $urandom}, 11, 1'b0, 1'b1);

        repeat (3) step();
        chk("rd_pending", 128'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Controller that sequences the AES-128 key-expansion engine.
- Accepts a 128-bit cipher key over a valid/ready handshake and pulses the engine start.
- Captures the 11 round keys the engine emits, one per cycle, into an internal 11x128 round-key table.
- Serves registered round-key reads to the cipher datapath, with forward (encrypt) and reversed (decrypt) indexing.

Parameters:
- NKEYS, 11, number of round keys captured (round 0..10); index width fixed at 4.
- TIMEOUT, 4, cycles allowed after kx_start for kx_state_in to leave IDLE before kx_err is raised.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- key_valid  in  1  new cipher key offered.
- key_in  in  128  cipher key, word0 = [127:96].
- key_ready  out  1  controller can accept a key.
- kx_start  out  1  one-cycle start pulse to the expansion engine.
- kx_key_out  out  128  held copy of the accepted key, drives engine key0..key3 inputs.
- kx_rk_in  in  128  engine round-key output {key0,key1,key2,key3}.
- kx_state_in  in  2  engine state: 0 = IDLE, nonzero = expanding.
- rk_rd_en  in  1  round-key read request.
- rk_rd_idx  in  4  requested round, 0..10.
- rk_dec  in  1  1 = return slot (10 - idx).
- rk_rd_data  out  128  registered round key.
- rk_rd_valid  out  1  rk_rd_data valid, one-cycle pulse.
- rk_rd_err  out  1  read rejected, one-cycle pulse.
- keys_valid  out  1  table holds a complete schedule.
- busy  out  1  expansion in progress.
- kx_err  out  1  sticky engine fault, cleared on next key acceptance.

Behaviour:
- Reset (RST=0, asynchronous):
  - state = IDLE, capture counter = 0, timeout counter = 0.
  - All outputs 0, except key_ready = 1.
  - Table contents cleared to 0.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE, READY.
  - key_ready = 1 in IDLE and READY only.
  - busy = 1 in LAUNCH, WAIT and CAPTURE.
- Key acceptance: key_valid & key_ready at edge T.
  - Latch key_in into kx_key_out; clear keys_valid and kx_err; go to LAUNCH.
- LAUNCH: kx_start = 1 for exactly this one cycle; then go to WAIT with timeout counter = 0.
- WAIT:
  - If kx_state_in != 0, capture kx_rk_in into slot 0, counter = 1, go to CAPTURE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set kx_err and go to IDLE.
- CAPTURE:
  - Each cycle with kx_state_in != 0, write kx_rk_in into slot[counter] and increment counter.
  - After the write to slot NKEYS-1, go to READY and set keys_valid on the same edge.
  - If kx_state_in == 0 before slot 10 is written, set kx_err, keep keys_valid = 0, go to IDLE.
- Nominal timing:
  - Key accepted at T; kx_start during T+1.
  - Captures at edges T+2..T+12; keys_valid = 1 from T+13.
- READY: holds until a new key is accepted.
  - A new key is accepted immediately; keys_valid drops at the next edge.
- Reads (one-cycle latency). A request sampled at edge E produces its result in the cycle after E:
  - If keys_valid = 1 and idx <= 10: rk_rd_data = slot[rk_dec ? 10-idx : idx], rk_rd_valid = 1.
  - If keys_valid = 0 or idx > 10: rk_rd_err = 1, rk_rd_data = 0.
  - rk_rd_data holds its last value when no read is issued.
- Simultaneous events:
  - Read and key acceptance in the same cycle: the read is served from the old table and reports valid, because keys_valid is sampled before it clears.
  - Reads during LAUNCH, WAIT or CAPTURE return errors.
- key_valid outside IDLE/READY is ignored; the key is not latched.
- Reset mid-expansion aborts immediately: table cleared, keys_valid = 0, kx_start = 0.

Test Plan:
- Reset then key 000102030405060708090a0b0c0d0e0f with a correct engine -> kx_start pulse at T+1; keys_valid at T+13; read idx 10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- With keys_valid = 1, read idx 0, rk_dec = 1 -> round-10 key 13111d7f...; read idx 0, rk_dec = 0 -> 000102030405060708090a0b0c0d0e0f.
- Read idx 11, and separately any read during CAPTURE -> rk_rd_err = 1, rk_rd_valid = 0, rk_rd_data = 0.
- Engine stub holds kx_state_in = 0 -> kx_err = 1 after 4 WAIT cycles; return to IDLE; key_ready = 1; keys_valid = 0.
- Engine stub drops kx_state_in after 5 captures -> kx_err = 1, keys_valid = 0; next key accepted clears kx_err.
- RST asserted at capture 6 -> all outputs 0 and key_ready = 1 at once; reads after release -> rk_rd_err = 1. Read and new key in the same READY cycle -> old data returned with valid, then keys_valid = 0.
